// File: rtl/thermometer_ramp_driver_pkg.sv
// ============================================================================
// Module : thermometer_pkg
// Brief  : Shared constants, state encoding and level-to-mask helper for the
//          thermometer ramp driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package thermometer_pkg;

  localparam int BIN_W = 5;
  localparam int N     = 2 ** BIN_W;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_HOLD     = 2'd1,
    ST_RAMP     = 2'd2,
    ST_BLANKING = 2'd3
  } state_e;

  // Equivalent to (2 << lvl) - 1 without needing an N+1 bit intermediate.
  function automatic logic [N-1:0] level_to_mask(input logic [BIN_W-1:0] lvl);
    logic [N-1:0] mask;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i <= int'(lvl));
    end
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/thermometer_ramp_driver_if.sv
// ============================================================================
// Module : thermometer_ramp_driver_if
// Brief  : Target command handshake plus thermometer output bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface thermometer_ramp_driver_if;
  import thermometer_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_code;
  logic             blank;
  logic [N-1:0]     therm_out;
  logic [BIN_W-1:0] level;
  logic             active;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_code, blank,
    input  in_ready, therm_out, level, active, busy, done
  );

  modport slave (
    input  in_valid, in_code, blank,
    output in_ready, therm_out, level, active, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/thermometer_ramp_driver_binary_to_thermometer.sv
// ============================================================================
// Module : binary_to_thermometer
// Brief  : Combinational binary level to thermometer mask decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module binary_to_thermometer
  import thermometer_pkg::*;
(
  input  logic [BIN_W-1:0] level,
  output logic [N-1:0]     mask
);

  assign mask = level_to_mask(level);

endmodule

`default_nettype wire

// File: rtl/thermometer_ramp_driver.sv
// ============================================================================
// Module : thermometer_ramp_driver
// Brief  : Rate-limited binary-to-thermometer driver with optional ramped blank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module thermometer_ramp_driver #(
  parameter int STEP       = 1,
  parameter int BLANK_RAMP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  thermometer_ramp_driver_if.slave bus
);
  import thermometer_pkg::*;

  localparam logic [1:0] S_OFF      = ST_OFF;
  localparam logic [1:0] S_HOLD     = ST_HOLD;
  localparam logic [1:0] S_RAMP     = ST_RAMP;
  localparam logic [1:0] S_BLANKING = ST_BLANKING;

  localparam logic [BIN_W:0] STEP_W = (BIN_W+1)'(STEP);

  logic [1:0]       state_q,  state_d;
  logic [BIN_W-1:0] level_q,  level_d;
  logic [BIN_W-1:0] target_q, target_d;
  logic             active_q, active_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [N-1:0]     therm_q,  therm_d;

  logic             accept;
  logic [BIN_W:0]   cur_w, tgt_w, dist_w, stride_w;
  logic [BIN_W-1:0] toward, lower;
  logic [N-1:0]     mask_w;

  // Ready looks at the live blank input so a blank request can never be
  // accepted as a target in the same cycle.
  assign bus.in_ready = ((state_q == S_OFF) || (state_q == S_HOLD)) && !bus.blank;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    active_d = active_q;
    done_d   = 1'b0;

    if (accept) begin
      target_d = bus.in_code;
    end

    // One extra bit keeps the step clamp from wrapping at either end.
    cur_w    = {1'b0, level_q};
    tgt_w    = {1'b0, target_d};
    dist_w   = (tgt_w > cur_w) ? (tgt_w - cur_w) : (cur_w - tgt_w);
    stride_w = (dist_w < STEP_W) ? dist_w : STEP_W;
    toward   = (tgt_w > cur_w) ? BIN_W'(cur_w + stride_w) : BIN_W'(cur_w - stride_w);
    lower    = (cur_w > STEP_W) ? BIN_W'(cur_w - STEP_W) : '0;

    if ((state_q != S_OFF) && (bus.blank || (state_q == S_BLANKING))) begin
      if ((BLANK_RAMP == 0) || ((state_q == S_BLANKING) && (level_q == '0))) begin
        state_d  = S_OFF;
        level_d  = '0;
        active_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        state_d = S_BLANKING;
        level_d = lower;
      end
    end else begin
      case (state_q)
        S_OFF: begin
          if (accept) begin
            active_d = 1'b1;
            level_d  = '0;
            if (bus.in_code == '0) begin
              state_d = S_HOLD;
              done_d  = 1'b1;
            end else begin
              state_d = S_RAMP;
            end
          end
        end
        S_HOLD, S_RAMP: begin
          if (accept || (state_q == S_RAMP)) begin
            level_d = toward;
            if (toward == target_d) begin
              state_d = S_HOLD;
              done_d  = 1'b1;
            end else begin
              state_d = S_RAMP;
            end
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end

    busy_d  = (state_d == S_RAMP) || (state_d == S_BLANKING);
    therm_d = active_d ? mask_w : '0;
  end

  binary_to_thermometer u_decode (
    .level (level_d),
    .mask  (mask_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      level_q  <= '0;
      target_q <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      therm_q  <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      therm_q  <= therm_d;
    end
  end

  assign bus.therm_out = therm_q;
  assign bus.level     = level_q;
  assign bus.active    = active_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_thermometer_ramp_driver.sv
// ============================================================================
// Module : tb_thermometer_ramp_driver
// Brief  : Directed scenarios plus randomized traffic against a reference model
//          for four parameterisations of the thermometer ramp driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_thermometer_ramp_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drv_valid = 1'b0;
  logic [4:0] drv_code  = '0;
  logic       drv_blank = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  thermometer_ramp_driver_if bus0 ();
  thermometer_ramp_driver_if bus1 ();
  thermometer_ramp_driver_if bus2 ();
  thermometer_ramp_driver_if bus3 ();

  assign bus0.in_valid = drv_valid; assign bus0.in_code = drv_code; assign bus0.blank = drv_blank;
  assign bus1.in_valid = drv_valid; assign bus1.in_code = drv_code; assign bus1.blank = drv_blank;
  assign bus2.in_valid = drv_valid; assign bus2.in_code = drv_code; assign bus2.blank = drv_blank;
  assign bus3.in_valid = drv_valid; assign bus3.in_code = drv_code; assign bus3.blank = drv_blank;

  thermometer_ramp_driver #(.STEP(1), .BLANK_RAMP(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  thermometer_ramp_driver #(.STEP(2), .BLANK_RAMP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  thermometer_ramp_driver #(.STEP(1), .BLANK_RAMP(0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  thermometer_ramp_driver #(.STEP(5), .BLANK_RAMP(1)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [31:0] o_therm [4];
  logic [4:0]  o_level [4];
  logic        o_active[4];
  logic        o_busy  [4];
  logic        o_done  [4];
  logic        o_ready [4];

  assign o_therm[0] = bus0.therm_out; assign o_level[0] = bus0.level; assign o_active[0] = bus0.active;
  assign o_busy[0]  = bus0.busy;      assign o_done[0]  = bus0.done;  assign o_ready[0]  = bus0.in_ready;
  assign o_therm[1] = bus1.therm_out; assign o_level[1] = bus1.level; assign o_active[1] = bus1.active;
  assign o_busy[1]  = bus1.busy;      assign o_done[1]  = bus1.done;  assign o_ready[1]  = bus1.in_ready;
  assign o_therm[2] = bus2.therm_out; assign o_level[2] = bus2.level; assign o_active[2] = bus2.active;
  assign o_busy[2]  = bus2.busy;      assign o_done[2]  = bus2.done;  assign o_ready[2]  = bus2.in_ready;
  assign o_therm[3] = bus3.therm_out; assign o_level[3] = bus3.level; assign o_active[3] = bus3.active;
  assign o_busy[3]  = bus3.busy;      assign o_done[3]  = bus3.done;  assign o_ready[3]  = bus3.in_ready;

  // Reference model: mode 0=off 1=hold 2=ramp 3=blanking
  int m_step[4] = '{1, 2, 1, 5};
  bit m_br  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  int m_mode[4] = '{default: 0};
  int m_lvl [4] = '{default: 0};
  int m_tgt [4] = '{default: 0};
  bit m_on  [4] = '{default: 1'b0};
  bit m_done[4] = '{default: 1'b0};

  function automatic logic [31:0] exp_mask(input int l);
    logic [63:0] w;
    w = (64'd2 << l) - 64'd1;
    return w[31:0];
  endfunction

  function automatic int approach(input int cur, input int tgt, input int st);
    if (tgt > cur) return (tgt - cur > st) ? cur + st : tgt;
    return (cur - tgt > st) ? cur - st : tgt;
  endfunction

  // Independent thermometer-to-binary decode; valid=0 for a non-thermometer word.
  function automatic void therm_to_bin(input logic [31:0] t, output int lvl, output bit valid);
    int ones;
    ones = $countones(t);
    lvl   = ones - 1;
    valid = (ones > 0) && (t == exp_mask(ones - 1));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      m_done[k] = 1'b0;
      if (rst) begin
        m_mode[k] = 0; m_lvl[k] = 0; m_tgt[k] = 0; m_on[k] = 1'b0;
      end else if (m_mode[k] != 0 && (drv_blank || m_mode[k] == 3)) begin
        if (!m_br[k] || (m_mode[k] == 3 && m_lvl[k] == 0)) begin
          m_mode[k] = 0; m_lvl[k] = 0; m_on[k] = 1'b0; m_done[k] = 1'b1;
        end else begin
          m_mode[k] = 3;
          m_lvl[k]  = (m_lvl[k] > m_step[k]) ? m_lvl[k] - m_step[k] : 0;
        end
      end else if (drv_valid && !drv_blank && (m_mode[k] == 0 || m_mode[k] == 1)) begin
        m_tgt[k] = int'(drv_code);
        if (m_mode[k] == 0) begin
          m_on[k] = 1'b1; m_lvl[k] = 0;
          if (m_tgt[k] == 0) begin m_mode[k] = 1; m_done[k] = 1'b1; end
          else m_mode[k] = 2;
        end else begin
          m_lvl[k] = approach(m_lvl[k], m_tgt[k], m_step[k]);
          if (m_lvl[k] == m_tgt[k]) begin m_mode[k] = 1; m_done[k] = 1'b1; end
          else m_mode[k] = 2;
        end
      end else if (m_mode[k] == 2) begin
        m_lvl[k] = approach(m_lvl[k], m_tgt[k], m_step[k]);
        if (m_lvl[k] == m_tgt[k]) begin m_mode[k] = 1; m_done[k] = 1'b1; end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; drv_valid = 1'b0; drv_code = '0; drv_blank = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [4:0] code);
    drv_valid = 1'b1; drv_code = code;
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  task automatic wait_level(input int k, input int lvl, output bit ok);
    for (int c = 0; c < 64 && int'(o_level[k]) != lvl; c++) @(negedge clk);
    ok = (int'(o_level[k]) == lvl);
  endtask

  task automatic test_reset();
    rst = 1'b1; drv_valid = 1'b0; drv_blank = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_therm[k] !== 32'h0 || o_level[k] !== 5'd0 || o_active[k] !== 1'b0 ||
          o_busy[k] !== 1'b0 || o_done[k] !== 1'b0 || o_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: therm=%h level=%0d act=%b busy=%b done=%b rdy=%b, want 0/0/0/0/0/1",
                 k, o_therm[k], o_level[k], o_active[k], o_busy[k], o_done[k], o_ready[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp_from_off();
    do_reset();
    send(5'd5);
    for (int i = 0; i <= 5; i++) begin
      checks++;
      if (o_therm[0] !== exp_mask(i) || o_done[0] !== (i == 5) || o_ready[0] !== (i == 5) ||
          o_busy[0] !== (i != 5)) begin
        errors++;
        $display("FAIL ramp_off step%0d: therm=%h done=%b rdy=%b busy=%b, want therm=%h done=%b rdy=%b busy=%b",
                 i, o_therm[0], o_done[0], o_ready[0], o_busy[0], exp_mask(i), i == 5, i == 5, i != 5);
      end
      @(negedge clk);
    end
    checks++;
    if (o_done[0] !== 1'b0 || o_therm[0] !== 32'h3F) begin
      errors++;
      $display("FAIL ramp_off settle: therm=%h done=%b, want 3f/0", o_therm[0], o_done[0]);
    end
  endtask

  task automatic test_step2_down();
    bit ok;
    do_reset();
    send(5'd31);
    for (int c = 0; c < 40 && !o_done[1]; c++) @(negedge clk);
    checks++;
    if (o_done[1] !== 1'b1 || o_therm[1] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL step2_up31: done=%b therm=%h, want 1/ffffffff", o_done[1], o_therm[1]);
    end
    ok = 1'b1;
    send(5'd28);
    checks++;
    if (o_level[1] !== 5'd29 || o_therm[1] !== 32'h3FFF_FFFF || o_done[1] !== 1'b0 || o_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL step2_29: level=%0d therm=%h done=%b busy=%b, want 29/3fffffff/0/1",
               o_level[1], o_therm[1], o_done[1], o_busy[1]);
    end
    @(negedge clk);
    checks++;
    if (o_level[1] !== 5'd28 || o_therm[1] !== 32'h1FFF_FFFF || o_done[1] !== 1'b1 || o_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL step2_28: level=%0d therm=%h done=%b busy=%b, want 28/1fffffff/1/0",
               o_level[1], o_therm[1], o_done[1], o_busy[1]);
    end
    @(negedge clk);
    checks++;
    if (o_level[1] !== 5'd28 || o_done[1] !== 1'b0 || !ok) begin
      errors++;
      $display("FAIL step2_hold: level=%0d done=%b, want 28/0", o_level[1], o_done[1]);
    end
  endtask

  task automatic test_hold_same();
    bit ok;
    do_reset();
    send(5'd10);
    wait_level(0, 10, ok);
    checks++;
    if (!ok || o_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_reach10: level=%0d done=%b, want 10/1", o_level[0], o_done[0]);
    end
    @(negedge clk);
    send(5'd10);
    checks++;
    if (o_therm[0] !== 32'h7FF || o_done[0] !== 1'b1 || o_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_same_done: therm=%h done=%b busy=%b, want 7ff/1/0", o_therm[0], o_done[0], o_busy[0]);
    end
    @(negedge clk);
    checks++;
    if (o_therm[0] !== 32'h7FF || o_done[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_same_after: therm=%h done=%b busy=%b, want 7ff/0/0", o_therm[0], o_done[0], o_busy[0]);
    end
  endtask

  task automatic test_blank_ramp();
    bit ok;
    do_reset();
    send(5'd20);
    wait_level(0, 6, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL blank_ramp_reach6: level=%0d, want 6", o_level[0]);
    end
    drv_blank = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      checks++;
      if (int'(o_level[0]) != i || o_therm[0] !== exp_mask(i) || o_active[0] !== 1'b1 ||
          o_busy[0] !== 1'b1 || o_done[0] !== 1'b0 || o_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL blank_ramp_down%0d: level=%0d therm=%h act=%b busy=%b done=%b rdy=%b",
                 i, o_level[0], o_therm[0], o_active[0], o_busy[0], o_done[0], o_ready[0]);
      end
    end
    @(negedge clk);
    checks++;
    if (o_therm[0] !== 32'h0 || o_active[0] !== 1'b0 || o_done[0] !== 1'b1 || o_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL blank_ramp_off: therm=%h act=%b done=%b busy=%b, want 0/0/1/0",
               o_therm[0], o_active[0], o_done[0], o_busy[0]);
    end
    @(negedge clk);
    checks++;
    if (o_done[0] !== 1'b0 || o_ready[0] !== 1'b0 || o_therm[0] !== 32'h0) begin
      errors++;
      $display("FAIL blank_ramp_stay: done=%b rdy=%b therm=%h, want 0/0/0", o_done[0], o_ready[0], o_therm[0]);
    end
    drv_blank = 1'b0;
    #1;
    checks++;
    if (o_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL blank_ramp_ready: rdy=%b, want 1", o_ready[0]);
    end
  endtask

  task automatic test_blank_clear();
    bit ok;
    do_reset();
    send(5'd20);
    wait_level(2, 6, ok);
    drv_blank = 1'b1; drv_valid = 1'b1; drv_code = 5'd3;
    @(negedge clk);
    checks++;
    if (!ok || o_therm[2] !== 32'h0 || o_level[2] !== 5'd0 || o_active[2] !== 1'b0 ||
        o_done[2] !== 1'b1 || o_busy[2] !== 1'b0 || o_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL blank_clear: therm=%h level=%0d act=%b done=%b busy=%b rdy=%b, want 0/0/0/1/0/0",
               o_therm[2], o_level[2], o_active[2], o_done[2], o_busy[2], o_ready[2]);
    end
    @(negedge clk);
    checks++;
    if (o_therm[2] !== 32'h0 || o_active[2] !== 1'b0 || o_done[2] !== 1'b0) begin
      errors++;
      $display("FAIL blank_clear_noaccept: therm=%h act=%b done=%b, want 0/0/0", o_therm[2], o_active[2], o_done[2]);
    end
    drv_blank = 1'b0; drv_valid = 1'b0;
  endtask

  task automatic test_reset_mid_ramp();
    bit ok;
    do_reset();
    send(5'd20);
    wait_level(0, 12, ok);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || o_therm[0] !== 32'h0 || o_level[0] !== 5'd0 || o_busy[0] !== 1'b0 ||
        o_done[0] !== 1'b0 || o_active[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: therm=%h level=%0d busy=%b done=%b act=%b, want all 0",
               o_therm[0], o_level[0], o_busy[0], o_done[0], o_active[0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int  prev_lvl[4];
    bit  prev_act[4];
    int  blank_left;
    int  dec;
    bit  vld;
    logic [31:0] e_therm;
    logic        e_rdy;
    do_reset();
    blank_left = 0;
    for (int k = 0; k < 4; k++) begin prev_lvl[k] = 0; prev_act[k] = 1'b0; end
    for (int c = 0; c < 900; c++) begin
      for (int k = 0; k < 4; k++) begin
        e_therm = m_on[k] ? exp_mask(m_lvl[k]) : 32'h0;
        e_rdy   = (m_mode[k] == 0 || m_mode[k] == 1) && !drv_blank;
        checks++;
        if (o_therm[k] !== e_therm || o_level[k] !== 5'(m_lvl[k]) || o_active[k] !== m_on[k] ||
            o_busy[k] !== (m_mode[k] >= 2) || o_done[k] !== m_done[k] || o_ready[k] !== e_rdy) begin
          errors++;
          $display("FAIL random c%0d dut%0d: therm=%h lvl=%0d act=%b busy=%b done=%b rdy=%b, want %h/%0d/%b/%b/%b/%b",
                   c, k, o_therm[k], o_level[k], o_active[k], o_busy[k], o_done[k], o_ready[k],
                   e_therm, m_lvl[k], m_on[k], m_mode[k] >= 2, m_done[k], e_rdy);
        end
        therm_to_bin(o_therm[k], dec, vld);
        checks++;
        if (o_active[k] ? (!vld || dec != int'(o_level[k])) : (o_therm[k] !== 32'h0)) begin
          errors++;
          $display("FAIL decode c%0d dut%0d: therm=%h decoded=%0d level=%0d act=%b",
                   c, k, o_therm[k], dec, o_level[k], o_active[k]);
        end
        if (prev_act[k] && o_active[k] && !rst) begin
          checks++;
          if (int'(o_level[k]) - prev_lvl[k] > m_step[k] || prev_lvl[k] - int'(o_level[k]) > m_step[k]) begin
            errors++;
            $display("FAIL slew c%0d dut%0d: level %0d -> %0d exceeds step %0d",
                     c, k, prev_lvl[k], o_level[k], m_step[k]);
          end
        end
        prev_lvl[k] = int'(o_level[k]);
        prev_act[k] = o_active[k];
      end
      rst = ($urandom_range(0, 299) == 0);
      if (blank_left > 0) blank_left--;
      else if ($urandom_range(0, 19) == 0) blank_left = $urandom_range(1, 14);
      drv_blank = (blank_left > 0);
      drv_valid = ($urandom_range(0, 2) != 0);
      drv_code  = 5'($urandom_range(0, 31));
      @(negedge clk);
    end
    rst = 1'b0; drv_valid = 1'b0; drv_blank = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_ramp_from_off();
    test_step2_down();
    test_hold_same();
    test_blank_ramp();
    test_blank_clear();
    test_reset_mid_ramp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/thermometer_ramp_driver.md
Name: thermometer_ramp_driver

Overview:
- Converts a 5-bit binary level into a 32-bit thermometer code for the unary DAC/segment array.
- This is the inverse of the thermometer-to-binary converter. Level n drives bits [n:0] high and bits [31:n+1] low. An all-zero output means "off/blanked".
- Moves the output toward a new target at a bounded rate (STEP levels per cycle) so the array never sees large code jumps.
- Sits between the control register block (valid/ready command source) and the analog array driver pins.

Parameters:
- BIN_W, 5, width of the binary level; N = 2**BIN_W = 32 thermometer bits (derived, not overridable).
- STEP, 1, maximum levels the output moves per cycle; legal range 1..N-1.
- BLANK_RAMP, 1, 1 = blank ramps down to level 0 and then clears to zero; 0 = blank clears the output to zero on the next cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a target level is presented.
- in_ready  output  1  driver can accept a target this cycle.
- in_code  input  BIN_W  target binary level 0..31.
- blank  input  1  level-sensitive request to turn the output off.
- therm_out  output  N  registered thermometer code.
- level  output  BIN_W  registered binary level currently driven; 0 while off.
- active  output  1  1 when therm_out is nonzero.
- busy  output  1  ramp in progress.
- done  output  1  one-cycle pulse, registered.

Behaviour:
- All outputs are registered.
- Reset: state=OFF, therm_out=0, level=0, active=0, busy=0, done=0, in_ready=1. Reset mid-ramp abandons the ramp immediately; no done pulse.
- States:
  - OFF: output is zero.
  - HOLD: settled at level.
  - RAMP: moving toward the latched target.
  - BLANKING: ramping down toward zero.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state is OFF or HOLD) && !blank.
  - in_code is latched as target on accept; in_code is ignored otherwise.
- OFF, on accept:
  - Next cycle: level=0, therm_out=32'h0000_0001, active=1.
  - If target==0: go to HOLD and pulse done that same cycle.
  - Otherwise: go to RAMP.
- HOLD, on accept:
  - Target==level: stay in HOLD; pulse done the next cycle; therm_out unchanged.
  - Otherwise: go to RAMP.
- RAMP, each cycle:
  - level moves toward target by min(STEP, |target-level|); it never overshoots.
  - When the new level equals target: go to HOLD, pulse done in the same cycle that therm_out first shows the target, deassert busy.
  - busy=1 in every RAMP and BLANKING cycle.
- Latency with STEP=1:
  - From OFF: n+1 cycles from accept to the done cycle.
  - From HOLD: |n-level| cycles (minimum 1).
- Invariants:
  - therm_out is always either 0 or a valid thermometer code consistent with level.
  - Only one level boundary moves per cycle: with STEP=1 at most one bit toggles per cycle, and STEP=k gives at most k toggles. The single exception is the immediate clear when BLANK_RAMP=0.
- blank (sampled every cycle; priority over accept and over RAMP):
  - BLANK_RAMP=0: next cycle therm_out=0, level=0, active=0, state=OFF, done pulse.
  - BLANK_RAMP=1: go to BLANKING. Level decreases by STEP per cycle, clamped at 0. On the cycle after level reaches 0, therm_out=0, active=0, state=OFF, done pulse.
  - blank asserted while already OFF: no effect, no done pulse.
  - blank deasserted during BLANKING: blanking still completes to OFF.
  - An in-flight RAMP target is discarded when blank arrives.
- in_valid held high while in_ready=0: no accept; the source must hold its data (standard valid/ready).
- Width rule: the level arithmetic uses BIN_W+1 bits internally so the step clamp cannot wrap. Level 31 yields 32'hFFFF_FFFF.

Decomposition:
- Package thermometer_pkg:
  - BIN_W and N constants.
  - State enum {OFF, HOLD, RAMP, BLANKING}.
  - Function level_to_mask(level) returning (2<<level)-1, with level 31 giving all ones.
- One natural sub-module: binary_to_thermometer, the combinational level-to-mask decoder, registered in the parent.
- The existing thermometer_to_binary converter, applied to therm_out, serves as the bench checker: it must return level whenever active=1.

Test Plan:
- Reset, then accept in_code=5 from OFF (STEP=1) -> therm_out goes 0x1, 0x3, 0x7, 0xF, 0x1F, 0x3F on consecutive cycles; done with 0x3F (6 cycles after accept); in_ready low throughout the ramp.
- From HOLD at 31 (0xFFFF_FFFF), accept 28 with STEP=2 -> level 29 then 28 (0x1FFF_FFFF); done pulses on the cycle 28 appears; never goes below 28.
- From HOLD at 10, accept 10 -> therm_out stays 0x7FF; done pulses 1 cycle later; busy stays 0.
- During a ramp 0->20, assert blank at level 6 with BLANK_RAMP=1 -> level steps 5,4,...,0, then therm_out=0 and active=0; one done pulse; target 20 never reached; in_ready returns only after blank drops.
- Same blank at level 6 with BLANK_RAMP=0 -> next cycle therm_out=0, state OFF, done pulse. Assert in_valid together with blank -> not accepted.
- Assert rst mid-ramp at level 12 -> next cycle therm_out=0, level=0, busy=0, no done pulse. Random target sequences -> checker decode equals level, and at most STEP levels change per cycle.
